// File: rtl/fuzzy_pi_driver_if.sv
// fuzzy_pi_driver_if: start/operand/result handshake between the PI driver and the serial fuzzy core.
interface fuzzy_pi_driver_if #(parameter int N = 16);
    logic         fz_start;
    logic [N-1:0] fz_x;
    logic [N-1:0] fz_y;
    logic [N-1:0] fz_out;
    logic         fz_rdy;
    modport master (output fz_start, fz_x, fz_y, input fz_out, fz_rdy);
    modport slave (input fz_start, fz_x, fz_y, output fz_out, fz_rdy);
endinterface

// File: rtl/fuzzy_pi_driver.sv
// fuzzy_pi_driver: samples sp/fb, drives the fuzzy core, integrates its increment into u.
// Define FUZZY_DRV_DEADBAND_EN to skip the core when |e| < DEADBAND.
module fuzzy_pi_driver #(
    parameter int N        = 16,
    parameter int KE_SH    = 0,
    parameter int KDE_SH   = 0,
    parameter int OUT_SH   = 0,
    parameter int TIMEOUT  = 1024,
    parameter int DEADBAND = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [N-1:0]      sp,
    input  logic [N-1:0]      fb,
    fuzzy_pi_driver_if.master fz,
    output logic [N-1:0]      u,
    output logic              u_valid,
    output logic              busy,
    output logic              overrun,
    output logic              timeout_err
);
    localparam int W  = 2 * N;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic signed [W-1:0] MAXV = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {{(N+1){1'b1}}, {(N-1){1'b0}}};
`ifdef FUZZY_DRV_DEADBAND_EN
    localparam logic DB_EN = 1'b1;
`else
    localparam logic DB_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, ACC} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          start, start_n, u_valid_n, overrun_n, terr_n, dead;
    logic [N-1:0]  x, x_n, y, y_n, e_cur, e_cur_n, e_prev, e_prev_n, inc, inc_n, u_n, e, de;

    function automatic logic signed [W-1:0] ext(input logic [N-1:0] a);
        return {{N{a[N-1]}}, a};
    endfunction

    function automatic logic [N-1:0] sat(input logic signed [W-1:0] v);
        return v > MAXV ? MAXV[N-1:0] : v < MINV ? MINV[N-1:0] : v[N-1:0];
    endfunction

    // Wide intermediates keep every difference and shift exact before clamping
    assign e    = sat(ext(sp) - ext(fb));
    assign de   = sat(ext(e) - ext(e_prev));
    assign dead = DB_EN && ((e[N-1] ? -ext(e) : ext(e)) < W'(DEADBAND));
    assign busy = state != IDLE;

    assign fz.fz_start = start;
    assign fz.fz_x     = x;
    assign fz.fz_y     = y;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        start_n   = 1'b0;
        x_n       = x;
        y_n       = y;
        e_cur_n   = e_cur;
        e_prev_n  = e_prev;
        inc_n     = inc;
        u_n       = u;
        u_valid_n = 1'b0;
        overrun_n = tick && state != IDLE;
        terr_n    = timeout_err;
        case (state)
            IDLE: if (tick) begin
                x_n     = sat(ext(e) <<< KE_SH);
                y_n     = sat(ext(de) <<< KDE_SH);
                e_cur_n = e;
                cnt_n   = '0;
                inc_n   = '0;
                start_n = !dead;
                state_n = dead ? ACC : WAIT;
            end
            // The cycle carrying fz_start cannot also accept a result
            WAIT: if (fz.fz_rdy && !start) begin
                inc_n   = fz.fz_out;
                state_n = ACC;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
                terr_n  = 1'b1;
                state_n = IDLE;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            ACC: begin
                u_n       = sat(ext(u) + (ext(inc) >>> OUT_SH));
                e_prev_n  = e_cur;
                u_valid_n = 1'b1;
                terr_n    = 1'b0;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            start       <= 1'b0;
            x           <= '0;
            y           <= '0;
            e_cur       <= '0;
            e_prev      <= '0;
            inc         <= '0;
            u           <= '0;
            u_valid     <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            start       <= start_n;
            x           <= x_n;
            y           <= y_n;
            e_cur       <= e_cur_n;
            e_prev      <= e_prev_n;
            inc         <= inc_n;
            u           <= u_n;
            u_valid     <= u_valid_n;
            overrun     <= overrun_n;
            timeout_err <= terr_n;
        end
    end
endmodule

// File: tb/tb_fuzzy_pi_driver.sv
// tb_fuzzy_pi_driver: directed table, corner sequences and random ops against an arithmetic model.
module tb_fuzzy_pi_driver;
    localparam int KE = 1, KDE = 2, OSH = 3, TO = 64;

    logic        clk = 1'b0, rst = 1'b1, tick = 1'b0;
    logic [15:0] sp = '0, fb = '0, u;
    logic        u_valid, busy, overrun, timeout_err;
    int          checks = 0, failures = 0;
    int          m_u = 0, m_ep = 0;

    always #5 clk = ~clk;

    fuzzy_pi_driver_if #(.N(16)) fz();

    fuzzy_pi_driver #(.N(16), .KE_SH(KE), .KDE_SH(KDE), .OUT_SH(OSH), .TIMEOUT(TO), .DEADBAND(16)) dut (
        .clk(clk), .rst(rst), .tick(tick), .sp(sp), .fb(fb), .fz(fz),
        .u(u), .u_valid(u_valid), .busy(busy), .overrun(overrun), .timeout_err(timeout_err)
    );

    typedef struct {
        logic [15:0] s, f, o;
        int          dly, ov;
        logic        late;
        logic [15:0] ex, ey, eu;
    } vec_t;

    function automatic int sat16(int v);
        return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
    endfunction

    function automatic int sx(logic [15:0] a);
        return int'(signed'(a));
    endfunction

    task automatic chk16(string n, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chkb(string n, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", n, act, exp);
        end
    endtask

    // One sample: dly<0 means the core never answers; ov injects a tick into WAIT; late ticks during ACC
    task automatic op(input logic [15:0] s, f, o, input int dly, ov, input logic late,
                      output logic [15:0] gx, gy);
        int e, de, ex, ey, n;
        e  = sat16(sx(s) - sx(f));
        de = sat16(e - m_ep);
        ex = sat16(e * (1 << KE));
        ey = sat16(de * (1 << KDE));
        @(negedge clk);
        sp = s; fb = f; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        gx = fz.fz_x; gy = fz.fz_y;
        chkb("start_hi", fz.fz_start, 1'b1);
        chkb("busy_hi", busy, 1'b1);
        chk16("fz_x", fz.fz_x, 16'(ex));
        chk16("fz_y", fz.fz_y, 16'(ey));
        @(negedge clk);
        chkb("start_lo", fz.fz_start, 1'b0);
        if (dly < 0) begin
            n = 0;
            while (busy && n < 200) begin
                @(negedge clk);
                n++;
            end
            chk16("to_cycles", 16'(n), 16'(TO - 1));
            chkb("to_err", timeout_err, 1'b1);
            chk16("to_u", u, 16'(m_u));
            chkb("to_uvalid", u_valid, 1'b0);
        end else begin
            for (int i = 0; i < dly; i++) begin
                if (i == ov) begin
                    sp = 16'($urandom); fb = 16'($urandom); tick = 1'b1;
                end
                @(negedge clk);
                tick = 1'b0;
                chkb("overrun", overrun, i == ov);
                chk16("x_hold", fz.fz_x, 16'(ex));
                chk16("y_hold", fz.fz_y, 16'(ey));
                chkb("no_uvalid", u_valid, 1'b0);
            end
            fz.fz_rdy = 1'b1; fz.fz_out = o;
            @(negedge clk);
            fz.fz_rdy = 1'b0; fz.fz_out = 16'($urandom); tick = late;
            chkb("acc_busy", busy, 1'b1);
            chkb("acc_uvalid", u_valid, 1'b0);
            m_u  = sat16(m_u + (sx(o) >>> OSH));
            m_ep = e;
            @(negedge clk);
            tick = 1'b0;
            chkb("uvalid", u_valid, 1'b1);
            chk16("u", u, 16'(m_u));
            chkb("to_clr", timeout_err, 1'b0);
            chkb("late_ov", overrun, late);
            chkb("idle", busy, 1'b0);
            @(negedge clk);
            chkb("uvalid_1cyc", u_valid, 1'b0);
        end
    endtask

    initial begin
        vec_t        vt[5];
        logic [15:0] gx, gy;
        int          d, o;
        vt = '{
            '{16'h1000, 16'h0000, 16'h0800, 18, -1, 1'b0, 16'h2000, 16'h4000, 16'h0100},
            '{16'h1000, 16'h0000, 16'h0800, 20,  5, 1'b0, 16'h2000, 16'h0000, 16'h0200},
            '{16'h7000, 16'h9000, 16'h7FFF,  3, -1, 1'b1, 16'h7FFF, 16'h7FFF, 16'h11FF},
            '{16'h9000, 16'h7000, 16'h8000,  0, -1, 1'b0, 16'h8000, 16'h8000, 16'h01FF},
            '{16'h0000, 16'h0000, 16'hFFF0, 62, -1, 1'b0, 16'h0000, 16'h7FFF, 16'h01FD}
        };
        fz.fz_rdy = 1'b0; fz.fz_out = '0;
        repeat (2) @(negedge clk);
        chk16("rst_u", u, 16'h0000);
        chk16("rst_x", fz.fz_x, 16'h0000);
        chkb("rst_start", fz.fz_start, 1'b0);
        chkb("rst_busy", busy, 1'b0);
        chkb("rst_uvalid", u_valid, 1'b0);
        chkb("rst_terr", timeout_err, 1'b0);
        rst = 1'b0;

        foreach (vt[k]) begin
            op(vt[k].s, vt[k].f, vt[k].o, vt[k].dly, vt[k].ov, vt[k].late, gx, gy);
            chk16("tbl_x", gx, vt[k].ex);
            chk16("tbl_y", gy, vt[k].ey);
            chk16("tbl_u", u, vt[k].eu);
        end

        repeat (8) op(16'h0000, 16'h0000, 16'h7FFF, 2, -1, 1'b0, gx, gy);
        chk16("u_sat_hi", u, 16'h7FFF);
        repeat (17) op(16'h0000, 16'h0000, 16'h8000, 1, -1, 1'b0, gx, gy);
        chk16("u_sat_lo", u, 16'h8000);

        op(16'h0100, 16'h0000, 16'h0000, -1, -1, 1'b0, gx, gy);
        op(16'h0100, 16'h0000, 16'h0100, 4, -1, 1'b0, gx, gy);
        op(16'h0200, 16'h0000, 16'h0000, -1, -1, 1'b0, gx, gy);

        // Reset in the middle of WAIT, then a stale result pulse
        @(negedge clk);
        sp = 16'h1000; fb = 16'h0000; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk16("mrst_u", u, 16'h0000);
        chk16("mrst_x", fz.fz_x, 16'h0000);
        chk16("mrst_y", fz.fz_y, 16'h0000);
        chkb("mrst_start", fz.fz_start, 1'b0);
        chkb("mrst_busy", busy, 1'b0);
        chkb("mrst_terr", timeout_err, 1'b0);
        chkb("mrst_uvalid", u_valid, 1'b0);
        chkb("mrst_ov", overrun, 1'b0);
        @(negedge clk);
        rst = 1'b0; m_u = 0; m_ep = 0;
        fz.fz_rdy = 1'b1; fz.fz_out = 16'h4000;
        @(negedge clk);
        fz.fz_rdy = 1'b0;
        repeat (3) @(negedge clk);
        chk16("stale_u", u, 16'h0000);
        chkb("stale_busy", busy, 1'b0);
        chkb("stale_uvalid", u_valid, 1'b0);

        for (int r = 0; r < 40; r++) begin
            d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 40));
            o = (d > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, d - 1)) : -1;
            op(16'($urandom), 16'($urandom), 16'($urandom), d, o, $urandom_range(0, 3) == 0, gx, gy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end
endmodule
